// File: rtl/produce_spawn_scheduler.sv
// Spawn scheduler: seeds the LFSR, turns its byte stream into timed fruit/bomb
// spawn events and queues them in a small FIFO behind a valid/ready handshake.
module produce_spawn_scheduler #(
    parameter int unsigned MIN_GAP   = 8,
    parameter int unsigned GAP_SHIFT = 0,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic        stop,
    input  logic        tick,
    input  logic [7:0]  seed_in,
    input  logic [7:0]  rnd,
    output logic        lfsr_select,
    output logic [7:0]  lfsr_seed,
    output logic        spawn_valid,
    input  logic        spawn_ready,
    output logic [2:0]  spawn_lane,
    output logic [1:0]  spawn_kind,
    output logic        busy,
    output logic [15:0] spawn_count,
    output logic [7:0]  drop_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSeed   = 2'd1;
    localparam logic [1:0] StReload = 2'd2;
    localparam logic [1:0] StWait   = 2'd3;

    localparam logic [11:0]   MinGap   = 12'(MIN_GAP);
    localparam logic [PtrW:0] FullCnt  = (PtrW + 1)'(DEPTH);
    localparam logic [PtrW:0] CntOne   = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    logic [1:0]      state_q, state_d;
    logic [11:0]     gap_q, gap_d;
    logic [7:0]      seed_q, seed_d;
    logic [4:0]      mem_q [DEPTH];
    logic [4:0]      mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic [15:0]     spawn_cnt_q, spawn_cnt_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic [7:0]  seed_fix;
    logic [11:0] gap_term;
    logic [1:0]  ev_kind;
    logic [4:0]  ev_entry;
    logic        push, pop, full, push_ok, drop, start_go;

    // An all-zero seed would lock the LFSR, so substitute a fixed pattern.
    assign seed_fix = (seed_in == 8'h00) ? 8'hA5 : seed_in;
    assign gap_term = {8'd0, rnd[7:4]} << GAP_SHIFT;
    assign ev_kind  = (rnd[7:5] == 3'b111) ? 2'd3 :
                      (rnd[4:3] == 2'b11)  ? 2'd0 : rnd[4:3];
    assign ev_entry = {rnd[2:0], ev_kind};
    assign start_go = (state_q == StIdle) && start && !stop;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_go) state_d = StSeed;
            end
            StSeed: begin
                state_d = stop ? StIdle : StReload;
            end
            StReload: begin
                if (stop) begin
                    state_d = StIdle;
                    gap_d   = 12'd0;
                end else begin
                    gap_d   = MinGap + gap_term;
                    state_d = StWait;
                end
            end
            default: begin
                if (stop) begin
                    state_d = StIdle;
                    gap_d   = 12'd0;
                end else if (tick) begin
                    if (gap_q <= 12'd1) begin
                        push    = 1'b1;
                        gap_d   = 12'd0;
                        state_d = StReload;
                    end else begin
                        gap_d = gap_q - 12'd1;
                    end
                end
            end
        endcase
    end

    assign full    = (count_q == FullCnt);
    assign pop     = spawn_valid && spawn_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push && (!full || pop);
    assign drop    = push && !push_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = ev_entry;
            wr_ptr_d        = wr_ptr_q + PtrOne;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PtrOne;
        if (push_ok && !pop) count_d = count_q + CntOne;
        else if (!push_ok && pop) count_d = count_q - CntOne;
    end

    always_comb begin
        seed_d      = (state_q == StSeed) ? seed_fix : seed_q;
        spawn_cnt_d = spawn_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (start_go) begin
            spawn_cnt_d = 16'd0;
            drop_cnt_d  = 8'd0;
        end else begin
            if (push_ok) spawn_cnt_d = spawn_cnt_q + 16'd1;
            if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= StIdle;
            gap_q       <= 12'd0;
            seed_q      <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            spawn_cnt_q <= 16'd0;
            drop_cnt_q  <= 8'd0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 5'd0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            seed_q      <= seed_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            spawn_cnt_q <= spawn_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign lfsr_select = (state_q == StSeed);
    assign lfsr_seed   = (state_q == StSeed) ? seed_fix : seed_q;
    assign spawn_valid = (count_q != '0);
    assign spawn_lane  = mem_q[rd_ptr_q][4:2];
    assign spawn_kind  = mem_q[rd_ptr_q][1:0];
    assign busy        = (state_q != StIdle);
    assign spawn_count = spawn_cnt_q;
    assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_produce_spawn_scheduler.sv
// Scoreboard bench for produce_spawn_scheduler: expected spawn entries are queued
// as stimulus creates them and checked as the DUT hands them out.
module tb_produce_spawn_scheduler;

    localparam int unsigned MinGap = 4;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, tick = 1'b0;
    logic [7:0]  seed_in = 8'h00, rnd = 8'h00;
    logic        lfsr_select, spawn_valid, busy;
    logic        spawn_ready = 1'b0;
    logic [7:0]  lfsr_seed, drop_count;
    logic [2:0]  spawn_lane;
    logic [1:0]  spawn_kind;
    logic [15:0] spawn_count;

    int n_cmp = 0;
    int n_fail = 0;
    int cur_gap = MinGap;
    logic [4:0] exp_q[$];

    produce_spawn_scheduler #(.MIN_GAP(MinGap), .GAP_SHIFT(0), .DEPTH(4)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .tick(tick),
        .seed_in(seed_in), .rnd(rnd), .lfsr_select(lfsr_select), .lfsr_seed(lfsr_seed),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_lane(spawn_lane),
        .spawn_kind(spawn_kind), .busy(busy), .spawn_count(spawn_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Expected {lane, kind} for a captured byte.
    function automatic logic [4:0] model(input logic [7:0] b);
        logic [1:0] k;
        if (b[7:5] == 3'b111) k = 2'd3;
        else if (b[4:3] == 2'b11) k = 2'd0;
        else k = b[4:3];
        return {b[2:0], k};
    endfunction

    // Monitor: every accepted handshake is checked against the scoreboard head.
    always @(negedge clk) begin
        if (clr_n && spawn_valid && spawn_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL handshake: unexpected entry lane=%0d kind=%0d, none required",
                         spawn_lane, spawn_kind);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({spawn_lane, spawn_kind} !== e) begin
                    n_fail++;
                    $display("FAIL handshake: got lane=%0d kind=%0d, required lane=%0d kind=%0d",
                             spawn_lane, spawn_kind, e[4:2], e[1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] seed, input logic [7:0] exp_seed,
                            input logic [7:0] gap_byte);
        seed_in = seed;
        start   = 1'b1;
        n_cmp++;
        if (lfsr_select !== 1'b0) begin
            n_fail++; $display("FAIL select_idle: got %b, required 0", lfsr_select);
        end
        step();
        start = 1'b0;
        rnd   = gap_byte;
        n_cmp++;
        if (lfsr_select !== 1'b1 || lfsr_seed !== exp_seed) begin
            n_fail++;
            $display("FAIL seed_pulse: got select=%b seed=%h, required 1/%h",
                     lfsr_select, lfsr_seed, exp_seed);
        end
        step();
        n_cmp++;
        if (lfsr_select !== 1'b0 || busy !== 1'b1 || lfsr_seed !== exp_seed) begin
            n_fail++;
            $display("FAIL seed_after: got select=%b busy=%b seed=%h, required 0/1/%h",
                     lfsr_select, busy, lfsr_seed, exp_seed);
        end
        step();
        rnd = 8'h00;
        cur_gap = MinGap + int'(gap_byte[7:4]);
    endtask

    // Issue cur_gap ticks; the last one captures ev. Next gap is always MinGap.
    task automatic fire(input logic [7:0] ev, input bit keep, input bit ready_last);
        for (int i = 1; i <= cur_gap; i++) begin
            tick = 1'b1;
            rnd  = (i == cur_gap) ? ev : 8'h00;
            if (i == cur_gap && ready_last) spawn_ready = 1'b1;
            step();
            tick = 1'b0;
            rnd  = 8'h00;
            if (i == cur_gap && keep) exp_q.push_back(model(ev));
            step();
        end
        cur_gap = MinGap;
    endtask

    task automatic drain();
        int n = 0;
        spawn_ready = 1'b1;
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        step();
        n_cmp++;
        if (exp_q.size() != 0 || spawn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got %0d left valid=%b, required 0 left valid=0",
                     exp_q.size(), spawn_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({lfsr_select, lfsr_seed, spawn_valid, spawn_lane, spawn_kind, busy,
             spawn_count, drop_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sel=%b seed=%h v=%b lane=%0d kind=%0d busy=%b sc=%0d dc=%0d, required all 0",
                     lfsr_select, lfsr_seed, spawn_valid, spawn_lane, spawn_kind, busy,
                     spawn_count, drop_count);
        end
        step();
        clr_n = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0 || spawn_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got busy=%b valid=%b, required 0/0", busy, spawn_valid);
        end
    endtask

    task automatic test_seed();
        do_start(8'h00, 8'hA5, 8'h00);
        do_stop();
        n_cmp++;
        if (busy !== 1'b0 || lfsr_seed !== 8'hA5) begin
            n_fail++; $display("FAIL stop_idle: got busy=%b seed=%h, required 0/a5", busy, lfsr_seed);
        end
        do_start(8'h3C, 8'h3C, 8'h00);
        do_stop();
    endtask

    task automatic test_gap();
        spawn_ready = 1'b1;
        do_start(8'h21, 8'h21, 8'h30);
        for (int i = 1; i <= 6; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        n_cmp++;
        if (spawn_count !== 16'd0 || spawn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_early: got count=%0d valid=%b after 6 ticks, required 0/0",
                     spawn_count, spawn_valid);
        end
        tick = 1'b1; rnd = 8'h0A; step();
        tick = 1'b0; rnd = 8'h00;
        exp_q.push_back(model(8'h0A));
        n_cmp++;
        if (spawn_count !== 16'd1) begin
            n_fail++; $display("FAIL gap_7th: got count=%0d, required 1", spawn_count);
        end
        step();
        cur_gap = MinGap;
        drain();
        do_stop();
    endtask

    task automatic test_decode();
        spawn_ready = 1'b1;
        do_start(8'h42, 8'h42, 8'h00);
        fire(8'hE5, 1'b1, 1'b0);
        fire(8'h18, 1'b1, 1'b0);
        fire(8'h0A, 1'b1, 1'b0);
        drain();
        n_cmp++;
        if (spawn_count !== 16'd3 || drop_count !== 8'd0) begin
            n_fail++; $display("FAIL decode_count: got %0d/%0d, required 3/0", spawn_count, drop_count);
        end
        do_stop();
    endtask

    task automatic test_full();
        logic [2:0] l0;
        logic [1:0] k0;
        spawn_ready = 1'b0;
        do_start(8'h55, 8'h55, 8'h00);
        fire(8'h01, 1'b1, 1'b0);
        fire(8'h0A, 1'b1, 1'b0);
        fire(8'h13, 1'b1, 1'b0);
        fire(8'hE4, 1'b1, 1'b0);
        fire(8'h05, 1'b0, 1'b0);
        fire(8'h0E, 1'b0, 1'b0);
        n_cmp++;
        if (spawn_valid !== 1'b1 || spawn_count !== 16'd4 || drop_count !== 8'd2) begin
            n_fail++;
            $display("FAIL full_counts: got valid=%b sc=%0d dc=%0d, required 1/4/2",
                     spawn_valid, spawn_count, drop_count);
        end
        l0 = spawn_lane;
        k0 = spawn_kind;
        n_cmp++;
        if ({l0, k0} !== exp_q[0]) begin
            n_fail++; $display("FAIL full_head: got %h, required %h", {l0, k0}, exp_q[0]);
        end
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (spawn_lane !== l0 || spawn_kind !== k0 || spawn_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL payload_stable: got lane=%0d kind=%0d, required lane=%0d kind=%0d",
                     spawn_lane, spawn_kind, l0, k0);
        end
        drain();
        do_stop();
    endtask

    task automatic test_full_pop();
        spawn_ready = 1'b0;
        do_start(8'h66, 8'h66, 8'h00);
        fire(8'h02, 1'b1, 1'b0);
        fire(8'h0B, 1'b1, 1'b0);
        fire(8'h14, 1'b1, 1'b0);
        fire(8'h1D, 1'b1, 1'b0);
        fire(8'hF7, 1'b1, 1'b1);
        drain();
        n_cmp++;
        if (drop_count !== 8'd0 || spawn_count !== 16'd5) begin
            n_fail++;
            $display("FAIL full_pop: got dc=%0d sc=%0d, required 0/5", drop_count, spawn_count);
        end
        do_stop();
    endtask

    task automatic test_stop();
        spawn_ready = 1'b0;
        do_start(8'h77, 8'h77, 8'h00);
        fire(8'h03, 1'b1, 1'b0);
        fire(8'h0C, 1'b1, 1'b0);
        tick = 1'b1; step(); tick = 1'b0; step();
        start = 1'b1; step(); start = 1'b0;
        n_cmp++;
        if (lfsr_select !== 1'b0 || spawn_count !== 16'd2) begin
            n_fail++;
            $display("FAIL start_busy: got select=%b sc=%0d, required 0/2", lfsr_select, spawn_count);
        end
        do_stop();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_busy: got %b, required 0", busy);
        end
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1; rnd = 8'(i * 37); step(); tick = 1'b0; step();
        end
        rnd = 8'h00;
        n_cmp++;
        if (spawn_count !== 16'd2 || spawn_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_hold: got sc=%0d valid=%b, required 2/1", spawn_count, spawn_valid);
        end
        drain();
        // Stop coinciding with the spawning tick suppresses the event.
        do_start(8'h11, 8'h11, 8'h00);
        for (int i = 1; i < cur_gap; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        tick = 1'b1; stop = 1'b1; rnd = 8'h05; step();
        tick = 1'b0; stop = 1'b0; rnd = 8'h00;
        step();
        n_cmp++;
        if (busy !== 1'b0 || spawn_count !== 16'd0 || spawn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_tick: got busy=%b sc=%0d valid=%b, required 0/0/0",
                     busy, spawn_count, spawn_valid);
        end
    endtask

    task automatic test_async_reset();
        spawn_ready = 1'b0;
        do_start(8'h88, 8'h88, 8'h00);
        fire(8'h04, 1'b1, 1'b0);
        fire(8'h0D, 1'b1, 1'b0);
        @(posedge clk);
        #1 spawn_ready = 1'b1;
        #2 clr_n = 1'b0;
        #1;
        n_cmp++;
        if (spawn_valid !== 1'b0 || busy !== 1'b0 || spawn_count !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b busy=%b sc=%0d, required 0/0/0",
                     spawn_valid, busy, spawn_count);
        end
        exp_q.delete();
        step();
        clr_n = 1'b1;
        spawn_ready = 1'b0;
        step();
        n_cmp++;
        if (spawn_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL after_reset: got valid=%b busy=%b, required 0/0", spawn_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_seed();
        test_gap();
        test_decode();
        test_full();
        test_full_pop();
        test_stop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/produce_spawn_scheduler.md
Name: produce_spawn_scheduler

Overview:
- Consumer of the 8-bit LFSR byte stream. Also the LFSR's seed controller.
- Turns pseudo-random bytes into timed fruit/bomb spawn events: a lane, a kind and a random inter-spawn gap.
- Events are buffered in a small FIFO and handed to the game-object manager over a valid/ready handshake.
- On start it drives the LFSR's seed-load select for exactly one cycle.

Parameters:
- MIN_GAP, 8: minimum ticks between spawns (1..255).
- GAP_SHIFT, 0: left-shift applied to the random gap term (0..3).
- DEPTH, 4: spawn FIFO entries (power of two, 2..16).

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: seed LFSR and begin scheduling
- stop  in  1  one-cycle pulse: halt scheduling
- tick  in  1  one-cycle game-frame pulse
- seed_in  in  8  requested LFSR seed
- rnd  in  8  LFSR output byte, shifts every clk
- lfsr_select  out  1  to LFSR select; 1 = load seed
- lfsr_seed  out  8  to LFSR seed
- spawn_valid  out  1  FIFO head valid
- spawn_ready  in  1  consumer accepts head
- spawn_lane  out  3  lane 0..7
- spawn_kind  out  2  0..2 = fruit type, 3 = bomb
- busy  out  1  state != IDLE
- spawn_count  out  16  events pushed since start, wraps at 0xFFFF->0
- drop_count  out  8  events lost to full FIFO, saturates at 255

Behaviour:
- Reset (clr_n=0, async): state IDLE; FIFO empty; every output 0.
- States:
  - IDLE: start -> SEED; all else ignored.
  - SEED (1 cycle): lfsr_select=1; lfsr_seed = seed_in, except seed_in==0 gives 8'hA5 (avoids the all-zero lock); -> RELOAD.
  - RELOAD (1 cycle): gap = MIN_GAP + (rnd[7:4] << GAP_SHIFT), 12-bit, no overflow; -> WAIT.
  - WAIT: each tick decrements gap. A tick with gap==1 captures rnd as an event and returns to RELOAD. An event therefore occurs exactly G ticks after RELOAD, where G is the loaded gap.
- lfsr_select is 0 in every state except SEED. lfsr_seed holds its last value.
- Event decode from the captured rnd:
  - lane = rnd[2:0]
  - kind = 3 if rnd[7:5]==3'b111; else rnd[4:3], with 2'b11 mapped to 0.
- RELOAD samples rnd one cycle after the capture, so the gap is taken from a fresh byte.
- Push:
  - FIFO not full: write the entry, spawn_count+1.
  - FIFO full: drop the entry, drop_count+1 (saturating).
  - Full with a pop in the same cycle: the push is accepted.
- Pop on spawn_valid && spawn_ready. spawn_lane/spawn_kind come from the FIFO head, registered, and stay stable while valid && !ready.
- Push into an empty FIFO: spawn_valid rises on the next cycle (1-cycle latency).
- stop in any non-IDLE state -> IDLE. Gap is cleared. FIFO contents are retained and keep draining. Counters hold.
- start and stop in the same cycle: stop wins; stays or goes IDLE.
- start while non-IDLE: ignored.
- start from IDLE: clears spawn_count and drop_count; the FIFO is not flushed.
- tick is ignored outside WAIT, including during SEED and RELOAD. stop arriving on the same cycle as a spawning tick: stop wins, no event.
- busy = (state != IDLE).

Test Plan:
- Reset, then start with seed_in=0x00 -> lfsr_select=1 for exactly one cycle with lfsr_seed=0xA5, then busy=1. seed_in=0x3C -> lfsr_seed=0x3C.
- MIN_GAP=4, GAP_SHIFT=0, rnd=0x30 in RELOAD -> event on the 7th subsequent tick, not the 6th.
- Capture rnd in turn as 0xE5, 0x18, 0x0A, with ready=1 -> events (lane 5, kind 3), (lane 0, kind 0), (lane 2, kind 1); spawn_count=3.
- DEPTH=4, ready=0, force 6 events -> 4 held, spawn_valid=1, drop_count=2, payload stable. Then ready=1 -> 4 pops in FIFO order.
- FIFO full, ready=1 coinciding with a push -> push accepted, drop_count unchanged.
- stop mid-WAIT with 2 entries queued -> busy=0 next cycle, no further events, both entries still delivered. Async clr_n=0 mid-handshake -> spawn_valid=0 immediately.
